video_copper: RTL and testbench
===============================

// Module: video_copper
// PURPOSE
// Per-scanline video register write sequencer. Holds a line-sorted command table
// {line, reg_sel, data} and replays it each frame. Writes go out on a shared write
// bus that the port decoder turns into the video register write strobes.
// CPU port writes always take priority; the copper stalls while cpu_busy is high.
// PARAMETERS
// AW        5   table address width; DEPTH = 2**AW entries
// MAX_LINE  8   max writes issued per scanline; excess entries dropped, ovf set
// PORTS
// clk          in   1    system clock
// res          in   1    synchronous active-high reset
// en           in   1    copper enable; low = IDLE, ptr cleared
// len          in   AW+1 number of valid table entries (0..DEPTH)
// tbl_we       in   1    table write strobe
// tbl_waddr    in   AW   table write address
// tbl_wdata    in   22   entry: [21:13] line, [12:8] reg_sel, [7:0] data
// frame_start  in   1    1-clk pulse, frame begin (int_start timing)
// line_start_s in   1    1-clk pulse, scanline begin
// vcnt         in   9    current scanline number, sampled on line_start_s
// cpu_busy     in   1    CPU video-port write in this cycle
// wr_stb       out  1    1-clk write strobe to port decoder
// wr_sel       out  5    target register index
// wr_data      out  8    write data
// busy         out  1    high in FETCH/RD/CHECK/ISSUE
// ovf          out  1    sticky: entries skipped/dropped this session
// BEHAVIOUR
// - Reset: wr_stb=0, wr_sel=0, wr_data=0, busy=0, ovf=0, ptr=0, state IDLE.
// - Table: DEPTH x 22 RAM; sync write; sync read, 1-clk latency. Reading the
//   address being written in the same cycle returns old data.
// - States: IDLE, WAIT, FETCH, RD, CHECK, ISSUE.
// - IDLE: when en=1, go to WAIT. en=0 in any state: go to IDLE, ptr=0, ovf=0,
//   no strobe.
// - frame_start: highest priority after res/en. ptr=0, wcnt=0, go to WAIT.
//   Suppresses any same-cycle ISSUE strobe.
// - line_start_s (not with frame_start): cur_line<=vcnt, wcnt=0, go to FETCH from
//   any non-IDLE state. Unfinished entries of the previous line are later skipped.
// - FETCH: if ptr==len, go to WAIT; else drive rd_addr=ptr and go to RD.
//   RD: wait for data, then CHECK.
// - CHECK (entry line E vs cur_line):
//   - E<cur_line: ovf=1, ptr++, go to FETCH.
//   - E>cur_line: go to WAIT.
//   - E==cur_line and wcnt==MAX_LINE: ovf=1, go to WAIT.
//   - E==cur_line otherwise: go to ISSUE.
// - ISSUE: if cpu_busy, hold with wr_stb=0. Else for exactly 1 clk:
//   wr_stb=1, wr_sel/wr_data from the entry; ptr++, wcnt++, go to FETCH.
//   wr_sel/wr_data hold their value between strobes.
// - Latency: line_start_s to first wr_stb is 4 clks with no stall.
//   Back-to-back strobes are 4 clks apart.
// - ptr/len: ptr never exceeds len. len=0 means never issue.
//   A len change takes effect at the next FETCH.
// - Entries must be sorted ascending by line. An unsorted entry stalls the walk
//   until the next frame (E>cur_line blocks); this is not an error.
// - Comparisons are unsigned 9-bit. vcnt is not range-checked.
// TESTING
// 1 en=1, len=2, entries {L10,sel3,0xAA},{L10,sel4,0x55}; line_start vcnt=10
//   -> wr_stb at +4 (sel3,0xAA) and +8 (sel4,0x55); ovf=0.
// 2 Same as 1 with cpu_busy held for 3 clks during ISSUE
//   -> first strobe delayed 3 clks; data unchanged; no strobe while busy.
// 3 MAX_LINE=8, 10 entries all at L20; lines 20,21
//   -> 8 strobes on L20; remaining 2 skipped on L21; ovf=1.
// 4 Entries at L5 and L7; frame_start asserted in the same cycle as the L5 ISSUE
//   -> no strobe; ptr=0; L5 replays correctly at the next line_start vcnt=5.
// 5 len=0, or en=0 mid-ISSUE -> no wr_stb; state IDLE; ovf cleared.
// 6 tbl_we to the entry at ptr in the same cycle as its read
//   -> old data issued; new data used next frame.

Source files
------------

// File: rtl/video_copper.sv
`default_nettype none
// ============================================================================
// Module   : video_copper
// Purpose  : Per-scanline video register write sequencer. Walks a line-sorted
//            command table {line, reg_sel, data} once per frame and replays the
//            entries belonging to the current scanline onto a shared write bus.
//            CPU port writes win the bus; the copper waits while cpu_busy is high.
// Revision : 1.0 - initial release
// ============================================================================
module video_copper #(
    parameter int AW       = 5,
    parameter int MAX_LINE = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic [AW:0]   len,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_waddr,
    input  logic [21:0]   tbl_wdata,
    input  logic          frame_start,
    input  logic          line_start_s,
    input  logic [8:0]    vcnt,
    input  logic          cpu_busy,
    output logic          wr_stb,
    output logic [4:0]    wr_sel,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          ovf
);

    localparam int c_DEPTH = 2 ** AW;
    localparam int c_PW    = AW + 1;
    localparam int c_WCW   = $clog2(MAX_LINE + 1);

    localparam logic [c_PW-1:0]  c_PTR_ONE  = c_PW'(1);
    localparam logic [c_WCW-1:0] c_WCNT_ONE = c_WCW'(1);
    localparam logic [c_WCW-1:0] c_WCNT_MAX = c_WCW'(MAX_LINE);

    // Walk states
    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_WAIT  = 3'd1;
    localparam logic [2:0] c_S_FETCH = 3'd2;
    localparam logic [2:0] c_S_RD    = 3'd3;
    localparam logic [2:0] c_S_CHECK = 3'd4;
    localparam logic [2:0] c_S_ISSUE = 3'd5;

    // Command table storage and the entry currently being examined
    logic [21:0]      r_mem [c_DEPTH];
    logic [21:0]      r_entry;

    // Walk registers
    logic [2:0]       r_state;
    logic [c_PW-1:0]  r_ptr;
    logic [c_WCW-1:0] r_wcnt;
    logic             r_ovf;
    logic [8:0]       r_cur_line;

    // Bus values held between strobes
    logic [4:0]       r_sel_hold;
    logic [7:0]       r_data_hold;

    // Next-state values from the walk logic
    logic [2:0]       w_state_nx;
    logic [c_PW-1:0]  w_ptr_nx;
    logic [c_WCW-1:0] w_wcnt_nx;
    logic             w_ovf_nx;
    logic [8:0]       w_cur_line_nx;
    logic             w_rd_en;
    logic             w_stb;

    // Entry fields
    logic [AW-1:0]    w_rd_addr;
    logic [8:0]       w_entry_line;
    logic [4:0]       w_entry_sel;
    logic [7:0]       w_entry_data;

    assign w_rd_addr    = r_ptr[AW-1:0];
    assign w_entry_line = r_entry[21:13];
    assign w_entry_sel  = r_entry[12:8];
    assign w_entry_data = r_entry[7:0];

    // Table write port; a same-cycle read of the written address sees old data
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            r_mem[tbl_waddr] <= tbl_wdata;
        end
    end

    // Table read port, captured only in FETCH so the entry stays stable until issued
    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_entry <= r_mem[w_rd_addr];
        end
    end

    // Walk state and counters
    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= c_S_IDLE;
            r_ptr      <= '0;
            r_wcnt     <= '0;
            r_ovf      <= 1'b0;
            r_cur_line <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_wcnt     <= w_wcnt_nx;
            r_ovf      <= w_ovf_nx;
            r_cur_line <= w_cur_line_nx;
        end
    end

    // Walk next-state: enable, frame restart and line restart override the walk
    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_wcnt_nx     = r_wcnt;
        w_ovf_nx      = r_ovf;
        w_cur_line_nx = r_cur_line;
        w_rd_en       = 1'b0;
        w_stb         = 1'b0;

        if (!en) begin
            w_state_nx = c_S_IDLE;
            w_ptr_nx   = '0;
            w_wcnt_nx  = '0;
            w_ovf_nx   = 1'b0;
        end else if (frame_start) begin
            w_state_nx = c_S_WAIT;
            w_ptr_nx   = '0;
            w_wcnt_nx  = '0;
        end else if (line_start_s && (r_state != c_S_IDLE)) begin
            // Anything left over from the previous line is skipped on this walk
            w_state_nx    = c_S_FETCH;
            w_cur_line_nx = vcnt;
            w_wcnt_nx     = '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    w_state_nx = c_S_WAIT;
                end
                c_S_WAIT: begin
                    w_state_nx = c_S_WAIT;
                end
                c_S_FETCH: begin
                    // Compare against len here so a changed len applies immediately
                    if (r_ptr >= len) begin
                        w_state_nx = c_S_WAIT;
                    end else begin
                        w_rd_en    = 1'b1;
                        w_state_nx = c_S_RD;
                    end
                end
                c_S_RD: begin
                    w_state_nx = c_S_CHECK;
                end
                c_S_CHECK: begin
                    if (w_entry_line < r_cur_line) begin
                        // Stale entry from an earlier line
                        w_ovf_nx   = 1'b1;
                        w_ptr_nx   = r_ptr + c_PTR_ONE;
                        w_state_nx = c_S_FETCH;
                    end else if (w_entry_line > r_cur_line) begin
                        // Belongs to a later line; also blocks on unsorted tables
                        w_state_nx = c_S_WAIT;
                    end else if (r_wcnt == c_WCNT_MAX) begin
                        // Per-line budget spent; entry is skipped on the next line
                        w_ovf_nx   = 1'b1;
                        w_state_nx = c_S_WAIT;
                    end else begin
                        w_state_nx = c_S_ISSUE;
                    end
                end
                c_S_ISSUE: begin
                    if (!cpu_busy) begin
                        w_stb      = 1'b1;
                        w_ptr_nx   = r_ptr + c_PTR_ONE;
                        w_wcnt_nx  = r_wcnt + c_WCNT_ONE;
                        w_state_nx = c_S_FETCH;
                    end
                end
                default: begin
                    w_state_nx = c_S_IDLE;
                end
            endcase
        end
    end

    // Remember the last issued write so the bus holds it between strobes
    always_ff @(posedge clk) begin
        if (res) begin
            r_sel_hold  <= '0;
            r_data_hold <= '0;
        end else if (w_stb) begin
            r_sel_hold  <= w_entry_sel;
            r_data_hold <= w_entry_data;
        end
    end

    assign wr_stb  = w_stb & ~res;
    assign wr_sel  = wr_stb ? w_entry_sel  : r_sel_hold;
    assign wr_data = wr_stb ? w_entry_data : r_data_hold;
    assign busy    = (r_state == c_S_FETCH) || (r_state == c_S_RD) ||
                     (r_state == c_S_CHECK) || (r_state == c_S_ISSUE);
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_video_copper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_video_copper
// Purpose  : Self-checking bench for video_copper: directed scenarios plus a
//            randomized table/line walk checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_copper;

    localparam int AW       = 5;
    localparam int DEPTH    = 32;
    localparam int MAX_LINE = 8;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          en = 1'b0;
    logic [AW:0]   len = '0;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_waddr = '0;
    logic [21:0]   tbl_wdata = '0;
    logic          frame_start = 1'b0;
    logic          line_start_s = 1'b0;
    logic [8:0]    vcnt = '0;
    logic          cpu_busy = 1'b0;
    logic          wr_stb;
    logic [4:0]    wr_sel;
    logic [7:0]    wr_data;
    logic          busy;
    logic          ovf;

    video_copper #(.AW(AW), .MAX_LINE(MAX_LINE)) dut (
        .clk(clk), .res(res), .en(en), .len(len),
        .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
        .frame_start(frame_start), .line_start_s(line_start_s), .vcnt(vcnt),
        .cpu_busy(cpu_busy), .wr_stb(wr_stb), .wr_sel(wr_sel),
        .wr_data(wr_data), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] c;
        logic [4:0]  s;
        logic [7:0]  d;
    } obs_t;

    obs_t        obs_q[$];
    int          busy_strobes = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ls = 0;
    logic [21:0] shadow [DEPTH];

    // Record every strobe away from the active edge
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            obs_q.push_back(obs_t'{c: cyc, s: wr_sel, d: wr_data});
            if (cpu_busy === 1'b1) busy_strobes = busy_strobes + 1;
        end
    end

    function automatic obs_t mk(input int c, input logic [4:0] s, input logic [7:0] d);
        return obs_t'{c: c, s: s, d: d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_entry(input int a, input logic [8:0] l, input logic [4:0] s, input logic [7:0] d);
        tbl_waddr = a[AW-1:0];
        tbl_wdata = {l, s, d};
        tbl_we    = 1'b1;
        shadow[a] = {l, s, d};
        tick(1);
        tbl_we    = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_line(input logic [8:0] v);
        vcnt         = v;
        line_start_s = 1'b1;
        ls           = cyc;
        tick(1);
        line_start_s = 1'b0;
    endtask

    task automatic restart();
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(1);
        pulse_frame();
        obs_q.delete();
    endtask

    task automatic test_reset();
        res = 1'b1;
        en  = 1'b1;
        tick(3);
        @(negedge clk);
        n_checks++; if (wr_stb !== 1'b0) begin n_errors++; $display("FAIL reset_wr_stb: got %b want 0", wr_stb); end
        n_checks++; if (wr_sel !== 5'd0) begin n_errors++; $display("FAIL reset_wr_sel: got %0d want 0", wr_sel); end
        n_checks++; if (wr_data !== 8'd0) begin n_errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        res = 1'b0;
        en  = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        obs_t e;
        write_entry(0, 9'd10, 5'd3, 8'hAA);
        write_entry(1, 9'd10, 5'd4, 8'h55);
        len = 6'd2;
        restart();
        pulse_line(9'd10);
        tick(14);
        n_checks++; if (obs_q.size() != 2) begin n_errors++; $display("FAIL basic_count: got %0d want 2", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            e = mk(ls + 4, 5'd3, 8'hAA);
            n_checks++; if (obs_q[0] !== e) begin n_errors++; $display("FAIL basic_first: got c=%0d s=%0d d=%h want c=%0d s=%0d d=%h", obs_q[0].c, obs_q[0].s, obs_q[0].d, e.c, e.s, e.d); end
        end
        if (obs_q.size() >= 2) begin
            e = mk(ls + 8, 5'd4, 8'h55);
            n_checks++; if (obs_q[1] !== e) begin n_errors++; $display("FAIL basic_second: got c=%0d s=%0d d=%h want c=%0d s=%0d d=%h", obs_q[1].c, obs_q[1].s, obs_q[1].d, e.c, e.s, e.d); end
        end
        @(negedge clk);
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        n_checks++; if ({wr_sel, wr_data} !== {5'd4, 8'h55}) begin n_errors++; $display("FAIL basic_hold: got s=%0d d=%h want s=4 d=55", wr_sel, wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        obs_t e;
        int   bs0;
        bs0 = busy_strobes;
        restart();
        pulse_line(9'd10);
        tick(3);
        cpu_busy = 1'b1;
        tick(3);
        cpu_busy = 1'b0;
        tick(10);
        n_checks++; if (obs_q.size() != 2) begin n_errors++; $display("FAIL stall_count: got %0d want 2", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            e = mk(ls + 7, 5'd3, 8'hAA);
            n_checks++; if (obs_q[0] !== e) begin n_errors++; $display("FAIL stall_first: got c=%0d s=%0d d=%h want c=%0d s=%0d d=%h", obs_q[0].c, obs_q[0].s, obs_q[0].d, e.c, e.s, e.d); end
        end
        if (obs_q.size() >= 2) begin
            e = mk(ls + 11, 5'd4, 8'h55);
            n_checks++; if (obs_q[1] !== e) begin n_errors++; $display("FAIL stall_second: got c=%0d s=%0d d=%h want c=%0d s=%0d d=%h", obs_q[1].c, obs_q[1].s, obs_q[1].d, e.c, e.s, e.d); end
        end
        n_checks++; if (busy_strobes != bs0) begin n_errors++; $display("FAIL stall_strobe_while_busy: got %0d want %0d", busy_strobes, bs0); end
    endtask

    task automatic test_max_line();
        obs_t e;
        for (int i = 0; i < 10; i++) write_entry(i, 9'd20, 5'(i), 8'(8'h30 + i));
        len = 6'd10;
        restart();
        pulse_line(9'd20);
        tick(60);
        n_checks++; if (obs_q.size() != MAX_LINE) begin n_errors++; $display("FAIL maxl_count: got %0d want %0d", obs_q.size(), MAX_LINE); end
        for (int i = 0; i < MAX_LINE; i++) begin
            if (i < obs_q.size()) begin
                e = mk(ls + 4 + 4 * i, 5'(i), 8'(8'h30 + i));
                n_checks++; if (obs_q[i] !== e) begin n_errors++; $display("FAIL maxl_strobe%0d: got c=%0d s=%0d d=%h want c=%0d s=%0d d=%h", i, obs_q[i].c, obs_q[i].s, obs_q[i].d, e.c, e.s, e.d); end
            end
        end
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL maxl_ovf_l20: got %b want 1", ovf); end
        obs_q.delete();
        pulse_line(9'd21);
        tick(30);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL maxl_l21_count: got %0d want 0", obs_q.size()); end
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL maxl_ovf_l21: got %b want 1", ovf); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL maxl_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame_abort();
        obs_t e;
        write_entry(0, 9'd5, 5'd1, 8'h11);
        write_entry(1, 9'd7, 5'd2, 8'h22);
        len = 6'd2;
        restart();
        pulse_line(9'd5);
        tick(3);
        frame_start = 1'b1;
        @(negedge clk);
        n_checks++; if (wr_stb !== 1'b0) begin n_errors++; $display("FAIL abort_stb: got %b want 0", wr_stb); end
        tick(1);
        frame_start = 1'b0;
        tick(5);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL abort_count: got %0d want 0", obs_q.size()); end
        pulse_line(9'd5);
        tick(8);
        e = mk(ls + 4, 5'd1, 8'h11);
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== e) begin n_errors++; $display("FAIL abort_replay_l5: got n=%0d c=%0d s=%0d d=%h want n=1 c=%0d s=%0d d=%h", obs_q.size(), obs_q[0].c, obs_q[0].s, obs_q[0].d, e.c, e.s, e.d); end
        obs_q.delete();
        pulse_line(9'd6);
        tick(8);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL abort_l6_count: got %0d want 0", obs_q.size()); end
        pulse_line(9'd7);
        tick(8);
        e = mk(ls + 4, 5'd2, 8'h22);
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== e) begin n_errors++; $display("FAIL abort_l7: got n=%0d c=%0d s=%0d d=%h want n=1 c=%0d s=%0d d=%h", obs_q.size(), obs_q[0].c, obs_q[0].s, obs_q[0].d, e.c, e.s, e.d); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL abort_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_disable();
        write_entry(0, 9'd10, 5'd1, 8'hC1);
        write_entry(1, 9'd10, 5'd2, 8'hC2);
        len = 6'd0;
        restart();
        pulse_line(9'd10);
        tick(10);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL len0_count: got %0d want 0", obs_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL len0_busy: got %b want 0", busy); end
        len = 6'd2;
        pulse_line(9'd11);
        tick(12);
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL dis_skip_ovf: got %b want 1", ovf); end
        pulse_frame();
        pulse_line(9'd10);
        tick(3);
        en = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_stb !== 1'b0) begin n_errors++; $display("FAIL dis_stb: got %b want 0", wr_stb); end
        tick(1);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL dis_busy: got %b want 0", busy); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL dis_ovf: got %b want 0", ovf); end
        pulse_line(9'd10);
        tick(8);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL dis_count: got %0d want 0", obs_q.size()); end
        en = 1'b1;
    endtask

    task automatic test_raw();
        obs_t e;
        write_entry(0, 9'd30, 5'd7, 8'h01);
        len = 6'd1;
        restart();
        pulse_line(9'd30);
        tbl_waddr = '0;
        tbl_wdata = {9'd30, 5'd7, 8'h99};
        tbl_we    = 1'b1;
        shadow[0] = {9'd30, 5'd7, 8'h99};
        tick(1);
        tbl_we    = 1'b0;
        tick(8);
        e = mk(ls + 4, 5'd7, 8'h01);
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== e) begin n_errors++; $display("FAIL raw_old: got n=%0d c=%0d s=%0d d=%h want n=1 c=%0d s=%0d d=%h", obs_q.size(), obs_q[0].c, obs_q[0].s, obs_q[0].d, e.c, e.s, e.d); end
        pulse_frame();
        obs_q.delete();
        pulse_line(9'd30);
        tick(8);
        e = mk(ls + 4, 5'd7, 8'h99);
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== e) begin n_errors++; $display("FAIL raw_new: got n=%0d c=%0d s=%0d d=%h want n=1 c=%0d s=%0d d=%h", obs_q.size(), obs_q[0].c, obs_q[0].s, obs_q[0].d, e.c, e.s, e.d); end
    endtask

    // Random sorted tables replayed over two frames; model walks the table per line
    task automatic test_random();
        logic [12:0] exp_q[$];
        logic [8:0]  ln;
        logic [8:0]  v;
        logic [21:0] ent;
        int          mptr;
        int          cnt;
        int          mlen;
        logic        movf;
        for (int t = 0; t < 4; t++) begin
            ln = 9'($urandom_range(0, 3));
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 2) == 0) ln = ln + 9'($urandom_range(1, 2));
                write_entry(i, ln, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            end
            mlen = $urandom_range(0, DEPTH);
            len  = 6'(mlen);
            restart();
            movf = 1'b0;
            for (int f = 0; f < 2; f++) begin
                if (f > 0) pulse_frame();
                mptr = 0;
                v = 9'($urandom_range(0, 1));
                while (v <= ln + 9'd2) begin
                    obs_q.delete();
                    exp_q.delete();
                    cnt = 0;
                    while (mptr < mlen) begin
                        ent = shadow[mptr];
                        if (ent[21:13] < v) begin
                            movf = 1'b1;
                            mptr++;
                        end else if (ent[21:13] > v) begin
                            break;
                        end else if (cnt == MAX_LINE) begin
                            movf = 1'b1;
                            break;
                        end else begin
                            exp_q.push_back(ent[12:0]);
                            mptr++;
                            cnt++;
                        end
                    end
                    pulse_line(v);
                    repeat (170) begin
                        cpu_busy = ($urandom_range(0, 3) == 0);
                        tick(1);
                    end
                    cpu_busy = 1'b0;
                    @(negedge clk);
                    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rnd_count t%0d f%0d line %0d: got %0d want %0d", t, f, v, obs_q.size(), exp_q.size()); end
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (k < obs_q.size()) begin
                            n_checks++; if ({obs_q[k].s, obs_q[k].d} !== exp_q[k]) begin n_errors++; $display("FAIL rnd_strobe t%0d line %0d #%0d: got s=%0d d=%h want s=%0d d=%h", t, v, k, obs_q[k].s, obs_q[k].d, exp_q[k][12:8], exp_q[k][7:0]); end
                        end
                    end
                    n_checks++; if (ovf !== movf) begin n_errors++; $display("FAIL rnd_ovf t%0d line %0d: got %b want %b", t, v, ovf, movf); end
                    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rnd_busy_end t%0d line %0d: got %b want 0", t, v, busy); end
                    v = v + 9'($urandom_range(1, 2));
                end
            end
        end
        n_checks++; if (busy_strobes != 0) begin n_errors++; $display("FAIL rnd_strobe_while_busy: got %0d want 0", busy_strobes); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_max_line();
        test_frame_abort();
        test_disable();
        test_raw();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
